uart_cmd_tx: RTL and testbench
==============================

UART_CMD_TX -- requirements
Module: uart_cmd_tx

Interface
REQ-001 Parameter CLK_FREQ, 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, 115200, line bit rate.
REQ-003 Parameter CMD_WIDTH, 16, command word width; integer multiple of DATA_BITS.
REQ-004 Parameter DATA_BITS, 8, data bits per UART frame, range 5..9.
REQ-005 Parameter PARITY, 1, parity mode: 0 none, 1 odd, 2 even.
REQ-006 Parameter STOP_BITS, 1, stop bits per frame, 1 or 2.
REQ-007 Port clk  input  1  single system clock; all logic on rising edge.
REQ-008 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 Port cmd_in  input  CMD_WIDTH  command word to transmit.
REQ-010 Port cmd_vld  input  1  command valid; source holds cmd_in stable until accepted.
REQ-011 Port cmd_rdy  output  1  block ready to accept a command.
REQ-012 Port tx  output  1  serial line, idle high.
REQ-013 Port busy  output  1  high from accept until last stop bit ends.
REQ-014 Port frame_done  output  1  one-cycle pulse in last cycle of each frame's final stop bit.
REQ-015 Port cmd_done  output  1  one-cycle pulse coincident with frame_done of the last frame of a command.

Function
REQ-016 BAUD_DIV SHALL equal CLK_FREQ/BAUD rounded to nearest integer; bit period exactly BAUD_DIV clk cycles.
REQ-017 Accept SHALL occur on a cycle with cmd_vld && cmd_rdy; cmd_in captured into an internal register that cycle.
REQ-018 cmd_rdy SHALL be high only in IDLE and low from the cycle after accept; cmd_vld while cmd_rdy low is ignored.
REQ-019 NUM_FRAMES = CMD_WIDTH/DATA_BITS frames SHALL be sent, most significant slice first, each slice LSB first.
REQ-020 Frame SHALL be: start bit 0, DATA_BITS data, parity bit if PARITY!=0, STOP_BITS stop bits at 1.
REQ-021 Odd parity bit = XNOR-reduce of slice; even parity bit = XOR-reduce of slice.
REQ-022 State machine IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> START (frames remain) or IDLE (last frame).
REQ-023 Start bit SHALL appear on tx the cycle after accept (latency 1).
REQ-024 Frames within one command SHALL be back-to-back, no idle gap.
REQ-025 With cmd_vld held high, next command SHALL be accepted the cycle after cmd_done, giving exactly one idle-high cycle between commands.
REQ-026 Changes on cmd_in after accept SHALL not affect the transmitted frames.
REQ-027 Bit counter and frame counter SHALL reset to 0 on each START entry / each accept respectively; no wrap beyond DATA_BITS-1 / NUM_FRAMES-1.
REQ-028 Elaboration SHALL fail if CMD_WIDTH % DATA_BITS != 0, BAUD_DIV < 2, PARITY > 2, or STOP_BITS not in {1,2}.

Reset
REQ-029 On rst_n low: tx=1, cmd_rdy=1 after release, busy=0, frame_done=0, cmd_done=0, state IDLE, counters 0.
REQ-030 Reset mid-frame SHALL drive tx high asynchronously and discard the in-flight command without any pulse.
REQ-031 First accept possible on the first rising clk edge after rst_n deasserts.

Structure
REQ-032 Package uart_pkg SHALL hold the state encoding, parity-mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and a baud-divisor function.
REQ-033 Sub-module uart_baud_gen SHALL provide the BAUD_DIV tick counter with enable and synchronous clear, restarted on every START entry.
REQ-034 Total RTL 120-400 lines; no other sub-modules.

Verification (CLK_FREQ=50000000, BAUD=115200, BAUD_DIV=434)
REQ-035 Defaults, cmd_in=16'hA55A, one cmd_vld pulse -> frames 0xA5 then 0x5A, each parity 1, 22 bits, cmd_done 9548 cycles after accept.
REQ-036 PARITY=2, STOP_BITS=2, DATA_BITS=8, CMD_WIDTH=8, cmd_in=8'h07 -> tx: 0,1,1,1,0,0,0,0,0,1(parity),1,1; 12 bits, 5208 cycles.
REQ-037 cmd_vld held high, two commands 16'h0001, 16'hFFFF -> exactly one idle-high cycle between first cmd_done and second start bit.
REQ-038 cmd_in toggled every cycle during transmission of 16'h1234 -> line decodes 0x12, 0x34 unchanged.
REQ-039 rst_n pulsed low mid DATA of frame 1 -> tx high immediately, no cmd_done, cmd_rdy high after release; new command 16'h00FF sends correctly.
REQ-040 PARITY=0, DATA_BITS=7, CMD_WIDTH=14, cmd_in=14'h2A55 -> two 9-bit frames 0x54, 0x55, no parity bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose: shared state encoding, parity-mode constants and baud divisor helper for uart_cmd_tx.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Purpose: bit-period tick generator; tick is high in the last cycle of every DIV-cycle period.
// Latency: first tick DIV cycles after clr (clr restarts the period at count 0).
// Backpressure: none; counts only while en is high.
// Ports: clk, rst_n (async active-low), en (count enable), clr (sync restart), tick (period end).
module uart_baud_gen
#(
    parameter int DIV = 434
)(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Purpose: serialises a CMD_WIDTH command as CMD_WIDTH/DATA_BITS back-to-back UART frames, MS slice first.
// Latency: start bit on tx the cycle after accept; cmd_done in the last cycle of the final stop bit.
// Backpressure: cmd_rdy high only in IDLE; cmd_vld is ignored while a command is in flight.
// Ports: clk, rst_n (async active-low), cmd_in/cmd_vld/cmd_rdy (command handshake),
//        tx (serial line, idle high), busy, frame_done / cmd_done (one-cycle pulses).
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int CMD_WIDTH = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMD_WIDTH-1:0] cmd_in,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 cmd_done
);

    localparam int BAUD_DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int NUM_FRAMES = CMD_WIDTH / DATA_BITS;
    localparam int BCW        = $clog2(DATA_BITS);
    localparam int FCW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);
    localparam logic [FCW-1:0] FRM_LAST = FCW'(NUM_FRAMES - 1);

    if ((CMD_WIDTH % DATA_BITS) != 0) begin : g_bad_width
        $error("uart_cmd_tx: CMD_WIDTH must be a multiple of DATA_BITS");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_cmd_tx: DATA_BITS must be 5..9");
    end
    if (BAUD_DIV < 2) begin : g_bad_div
        $error("uart_cmd_tx: CLK_FREQ/BAUD must be at least 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_cmd_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_cmd_tx: STOP_BITS must be 1 or 2");
    end

    state_t               state, state_nxt;
    logic [CMD_WIDTH-1:0] cmd_q, cmd_nxt;
    logic [BCW-1:0]       bit_cnt, bit_nxt;
    logic [FCW-1:0]       frm_cnt, frm_nxt;
    logic                 stop_cnt, stop_nxt;
    logic                 tx_nxt;
    logic                 tick;
    logic                 accept;
    logic                 start_entry;
    logic                 last_stop;
    logic [DATA_BITS-1:0] slice;
    logic                 par_bit;

    // The captured command is shifted up one slice per frame, so the frame
    // being sent is always the top DATA_BITS of cmd_q.
    assign slice       = cmd_q[CMD_WIDTH-1 -: DATA_BITS];
    assign par_bit     = (PARITY == PAR_ODD) ? ~^slice : ^slice;
    assign cmd_rdy     = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign accept      = cmd_vld && cmd_rdy;
    assign last_stop   = (STOP_BITS == 1) || stop_cnt;
    assign frame_done  = (state == ST_STOP) && tick && last_stop;
    assign cmd_done    = frame_done && (frm_cnt == FRM_LAST);
    assign start_entry = (state_nxt == ST_START) && (state != ST_START);

    uart_baud_gen #(
        .DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .clr   (start_entry),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        bit_nxt   = bit_cnt;
        frm_nxt   = frm_cnt;
        stop_nxt  = stop_cnt;
        tx_nxt    = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_START;
                    cmd_nxt   = cmd_in;
                    bit_nxt   = '0;
                    frm_nxt   = '0;
                end
            end
            ST_START: begin
                if (tick) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_nxt  = 1'b0;
                    end else begin
                        bit_nxt = bit_cnt + BCW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_nxt = ST_STOP;
                    stop_nxt  = 1'b0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (!last_stop) begin
                        stop_nxt = 1'b1;
                    end else if (frm_cnt == FRM_LAST) begin
                        state_nxt = ST_IDLE;
                        frm_nxt   = '0;
                    end else begin
                        state_nxt = ST_START;
                        frm_nxt   = frm_cnt + FCW'(1);
                        bit_nxt   = '0;
                        cmd_nxt   = cmd_q << DATA_BITS;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // tx is registered from the next-state view so the line never glitches.
        // cmd_q only changes on the way into START, so slice is valid for DATA/PARITY.
        unique case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = slice[bit_nxt];
            ST_PARITY: tx_nxt = par_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cmd_q    <= '0;
            bit_cnt  <= '0;
            frm_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_nxt;
            cmd_q    <= cmd_nxt;
            bit_cnt  <= bit_nxt;
            frm_cnt  <= frm_nxt;
            stop_cnt <= stop_nxt;
            tx       <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Purpose: scoreboard bench for uart_cmd_tx across three parameter sets (8O1x2, 8E2x1, 7N1x2).
// Latency: expected frame start = accept cycle + 1 + k * frame length.
// Backpressure: stimulus waits on cmd_rdy; a per-instance line monitor decodes tx and pops expectations.
module tb_uart_cmd_tx;

    localparam int DIV = 434;

    typedef struct {
        logic [8:0] dat;
        logic       par;
        bit         last;
        int         start;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cmd_in_a [3];
    logic [2:0]  cmd_vld_a;
    logic [2:0]  cmd_rdy_a, tx_a, busy_a, frame_done_a, cmd_done_a;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt [3] = '{0, 0, 0};
    int cd_cnt [3] = '{0, 0, 0};

    frame_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (frame_done_a[i]) fd_cnt[i] <= fd_cnt[i] + 1;
            if (cmd_done_a[i])   cd_cnt[i] <= cd_cnt[i] + 1;
        end
    end

    uart_cmd_tx u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in_a[0]), .cmd_vld(cmd_vld_a[0]),
        .cmd_rdy(cmd_rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]),
        .frame_done(frame_done_a[0]), .cmd_done(cmd_done_a[0])
    );

    uart_cmd_tx #(.CMD_WIDTH(8), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in_a[1][7:0]), .cmd_vld(cmd_vld_a[1]),
        .cmd_rdy(cmd_rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]),
        .frame_done(frame_done_a[1]), .cmd_done(cmd_done_a[1])
    );

    uart_cmd_tx #(.CMD_WIDTH(14), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in_a[2][13:0]), .cmd_vld(cmd_vld_a[2]),
        .cmd_rdy(cmd_rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]),
        .frame_done(frame_done_a[2]), .cmd_done(cmd_done_a[2])
    );

    function automatic int cfg_db(input int id);
        return (id == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_nf(input int id);
        return (id == 1) ? 1 : 2;
    endfunction
    function automatic int cfg_par(input int id);
        return (id == 0) ? 1 : (id == 1) ? 2 : 0;
    endfunction
    function automatic int cfg_stop(input int id);
        return (id == 1) ? 2 : 1;
    endfunction
    function automatic int cfg_nb(input int id);
        return 1 + cfg_db(id) + ((cfg_par(id) != 0) ? 1 : 0) + cfg_stop(id);
    endfunction

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic frame_t qpop(input int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int id, input frame_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void qclear(input int id);
        case (id)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endfunction

    // Expected parity bit: odd mode makes the total count of ones odd, even mode even.
    function automatic logic exp_par(input int id, input int sl);
        int ones = 0;
        for (int b = 0; b < 9; b++) ones += (sl >> b) & 1;
        if (cfg_par(id) == 1) return (ones % 2 == 0);
        return (ones % 2 == 1);
    endfunction

    function automatic void push_cmd(input int id, input logic [15:0] data, input int acc);
        frame_t e;
        int db = cfg_db(id);
        int nf = cfg_nf(id);
        int sl;
        for (int k = 0; k < nf; k++) begin
            sl      = (int'(data) >> (db * (nf - 1 - k))) & ((1 << db) - 1);
            e.dat   = 9'(sl);
            e.par   = exp_par(id, sl);
            e.last  = (k == nf - 1);
            e.start = acc + 1 + k * cfg_nb(id) * DIV;
            qpush(id, e);
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic adv(inout int off, input int tgt, inout bit ab);
        while (!ab && off < tgt) begin
            @(negedge clk);
            off++;
            if (!rst_n) ab = 1'b1;
        end
    endtask

    // Line monitor: on a falling tx edge, samples every bit mid-period and checks the pulses.
    task automatic monitor(input int id);
        frame_t     e;
        bit         have, ab;
        int         off, t0;
        logic [8:0] d;
        logic       sb, pb, fd_pre, fd_end, cd_end;
        logic [1:0] stp;
        forever begin
            @(negedge clk);
            if (rst_n && !tx_a[id]) begin
                t0   = cyc;
                off  = 0;
                ab   = 1'b0;
                have = (qsize(id) != 0);
                check($sformatf("u%0d frame expected", id), have, 1);
                if (have) e = qpop(id);
                d   = '0;
                pb  = 1'b0;
                stp = '0;
                adv(off, DIV / 2, ab);
                sb = tx_a[id];
                for (int i = 0; i < cfg_db(id); i++) begin
                    adv(off, (1 + i) * DIV + DIV / 2, ab);
                    d[i] = tx_a[id];
                end
                if (cfg_par(id) != 0) begin
                    adv(off, (1 + cfg_db(id)) * DIV + DIV / 2, ab);
                    pb = tx_a[id];
                end
                for (int s = 0; s < cfg_stop(id); s++) begin
                    adv(off, (cfg_nb(id) - cfg_stop(id) + s) * DIV + DIV / 2, ab);
                    stp[s] = tx_a[id];
                end
                adv(off, cfg_nb(id) * DIV - 2, ab);
                fd_pre = frame_done_a[id];
                adv(off, cfg_nb(id) * DIV - 1, ab);
                fd_end = frame_done_a[id];
                cd_end = cmd_done_a[id];
                if (ab) begin
                    qclear(id);
                end else if (have) begin
                    check($sformatf("u%0d start cycle", id), t0, e.start);
                    check($sformatf("u%0d start bit", id), sb, 0);
                    check($sformatf("u%0d data", id), d, e.dat);
                    if (cfg_par(id) != 0) check($sformatf("u%0d parity", id), pb, e.par);
                    for (int s = 0; s < cfg_stop(id); s++)
                        check($sformatf("u%0d stop%0d", id, s), stp[s], 1);
                    check($sformatf("u%0d frame_done early", id), fd_pre, 0);
                    check($sformatf("u%0d frame_done", id), fd_end, 1);
                    check($sformatf("u%0d cmd_done", id), cd_end, e.last);
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic send_cmd(input int id, input logic [15:0] data, input bit hold, output int acc);
        int n = 0;
        @(negedge clk);
        cmd_in_a[id]  = data;
        cmd_vld_a[id] = 1'b1;
        while (!cmd_rdy_a[id] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d rdy before accept", id), cmd_rdy_a[id], 1);
        acc = cyc;
        push_cmd(id, data, acc);
        @(negedge clk);
        check($sformatf("u%0d rdy after accept", id), cmd_rdy_a[id], 0);
        if (!hold) cmd_vld_a[id] = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        @(negedge clk);
        while (!(cmd_rdy_a[id] && qsize(id) == 0) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d idle reached", id), cmd_rdy_a[id] && (qsize(id) == 0), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #950000;
        n_bad++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int a, a1;
        int n;
        rst_n     = 1'b0;
        cmd_vld_a = '0;
        for (int i = 0; i < 3; i++) cmd_in_a[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d reset tx", i), tx_a[i], 1);
            check($sformatf("u%0d reset rdy", i), cmd_rdy_a[i], 1);
            check($sformatf("u%0d reset busy", i), busy_a[i], 0);
            check($sformatf("u%0d reset frame_done", i), frame_done_a[i], 0);
            check($sformatf("u%0d reset cmd_done", i), cmd_done_a[i], 0);
        end

        // 0xA55A with cmd_vld already high: accepted on the first edge after release.
        cmd_in_a[0]  = 16'hA55A;
        cmd_vld_a[0] = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b1;
        a = cyc;
        push_cmd(0, 16'hA55A, a);
        @(negedge clk);
        check("u0 rdy after first accept", cmd_rdy_a[0], 0);
        cmd_vld_a[0] = 1'b0;
        wait_idle(0);

        // Held cmd_vld: second command accepted the cycle after cmd_done.
        send_cmd(0, 16'h0001, 1'b1, a1);
        cmd_in_a[0] = 16'hFFFF;
        push_cmd(0, 16'hFFFF, a1 + 9549);
        n = 0;
        while (!cmd_rdy_a[0] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("u0 second accept cycle", cyc, a1 + 9549);
        @(negedge clk);
        cmd_vld_a[0] = 1'b0;
        wait_idle(0);

        // cmd_in toggling and a stray cmd_vld window while busy.
        send_cmd(0, 16'h1234, 1'b0, a);
        for (int i = 0; i < 9600; i++) begin
            cmd_in_a[0]  = ~cmd_in_a[0];
            cmd_vld_a[0] = (i >= 100 && i < 5000);
            if (i == 200) begin
                check("u0 rdy while busy", cmd_rdy_a[0], 0);
                check("u0 busy mid command", busy_a[0], 1);
            end
            @(negedge clk);
        end
        cmd_vld_a[0] = 1'b0;
        wait_idle(0);

        // Reset in the data bits of the first frame, then a clean command.
        send_cmd(0, 16'hC3A5, 1'b0, a);
        repeat (1500) @(negedge clk);
        check("u0 tx before reset", tx_a[0], 0);
        #2 rst_n = 1'b0;
        #1;
        check("u0 tx in reset", tx_a[0], 1);
        check("u0 busy in reset", busy_a[0], 0);
        check("u0 rdy in reset", cmd_rdy_a[0], 1);
        check("u0 cmd_done in reset", cmd_done_a[0], 0);
        check("u0 frame_done in reset", frame_done_a[0], 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("u0 rdy after reset", cmd_rdy_a[0], 1);
        send_cmd(0, 16'h00FF, 1'b0, a);
        wait_idle(0);

        // Even parity, two stop bits, single 8-bit frame.
        send_cmd(1, 16'h0007, 1'b0, a);
        wait_idle(1);

        // No parity, 7-bit slices.
        send_cmd(2, 16'h2A55, 1'b0, a);
        wait_idle(2);

        check("u0 cmd_done count", cd_cnt[0], 5);
        check("u0 frame_done count", fd_cnt[0], 10);
        check("u1 cmd_done count", cd_cnt[1], 1);
        check("u1 frame_done count", fd_cnt[1], 1);
        check("u2 cmd_done count", cd_cnt[2], 1);
        check("u2 frame_done count", fd_cnt[2], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
